// File: rtl/bitscan_encoder_if.sv
// Handshake bundle for bitscan_encoder: request vector in, one bit index per beat out.
// o_zero is only present when ENC_ZERO_EVT_EN is defined.
interface bitscan_encoder_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] i;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] o;
  logic         o_valid;
  logic         o_ready;
  logic         o_last;
`ifdef ENC_ZERO_EVT_EN
  logic         o_zero;
`endif

`ifdef ENC_ZERO_EVT_EN
  modport master (output i, i_valid, o_ready, input i_ready, o, o_valid, o_last, o_zero);
  modport slave  (input i, i_valid, o_ready, output i_ready, o, o_valid, o_last, o_zero);
`else
  modport master (output i, i_valid, o_ready, input i_ready, o, o_valid, o_last);
  modport slave  (input i, i_valid, o_ready, output i_ready, o, o_valid, o_last);
`endif
endinterface

// File: rtl/bitscan_encoder.sv
// Registered N-to-log2(N) encoder: emits the index of every set bit of an accepted vector,
// one per beat, in priority order. Define ENC_ZERO_EVT_EN to emit a beat for all-zero vectors.
module bitscan_encoder #(
  parameter int N         = 8,
  parameter int W         = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic             clk,
  input logic             rst,
  bitscan_encoder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
`ifdef ENC_ZERO_EVT_EN
  localparam logic [1:0] ZERO = 2'd2;
`endif
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] o_q, o_d;
  logic         o_last_q, o_last_d;
  logic         o_valid_q, o_valid_d;
`ifdef ENC_ZERO_EVT_EN
  logic         o_zero_q, o_zero_d;
`endif

  logic         i_ready_c;
  logic         beat_done;
  logic         accept;
  logic [N-1:0] pend_rem;

  function automatic logic [W-1:0] find_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    // The last match in the loop wins, so loop direction sets the priority.
    if (MSB_FIRST) begin
      for (int k = 0; k < N; k++) if (v[k]) idx = k[W-1:0];
    end else begin
      for (int k = N - 1; k >= 0; k--) if (v[k]) idx = k[W-1:0];
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  assign i_ready_c = (state_q == IDLE) | (o_valid_q & bus.o_ready & o_last_q);
  assign beat_done = o_valid_q & bus.o_ready;
  assign accept    = bus.i_valid & i_ready_c;
  assign pend_rem  = pend_q & ~(ONE << o_q);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    o_d       = o_q;
    o_last_d  = o_last_q;
    o_valid_d = o_valid_q;
`ifdef ENC_ZERO_EVT_EN
    o_zero_d  = o_zero_q;
`endif

    if (beat_done) begin
      if (o_last_q) begin
        state_d   = IDLE;
        pend_d    = '0;
        o_d       = '0;
        o_last_d  = 1'b0;
        o_valid_d = 1'b0;
`ifdef ENC_ZERO_EVT_EN
        o_zero_d  = 1'b0;
`endif
      end else begin
        pend_d   = pend_rem;
        o_d      = find_idx(pend_rem);
        o_last_d = single_bit(pend_rem);
      end
    end

    // A new vector may land in the same cycle the final beat retires.
    if (accept) begin
      if (bus.i != '0) begin
        state_d   = SCAN;
        pend_d    = bus.i;
        o_d       = find_idx(bus.i);
        o_last_d  = single_bit(bus.i);
        o_valid_d = 1'b1;
`ifdef ENC_ZERO_EVT_EN
        o_zero_d  = 1'b0;
`endif
      end else begin
`ifdef ENC_ZERO_EVT_EN
        state_d   = ZERO;
        pend_d    = '0;
        o_d       = '0;
        o_last_d  = 1'b1;
        o_valid_d = 1'b1;
        o_zero_d  = 1'b1;
`else
        state_d   = IDLE;
        pend_d    = '0;
        o_d       = '0;
        o_last_d  = 1'b0;
        o_valid_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      o_q       <= '0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
`ifdef ENC_ZERO_EVT_EN
      o_zero_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      o_q       <= o_d;
      o_last_q  <= o_last_d;
      o_valid_q <= o_valid_d;
`ifdef ENC_ZERO_EVT_EN
      o_zero_q  <= o_zero_d;
`endif
    end
  end

  assign bus.i_ready = i_ready_c;
  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
`ifdef ENC_ZERO_EVT_EN
  assign bus.o_zero  = o_zero_q;
`endif

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed bench for bitscan_encoder: an LSB-first and an MSB-first instance share clk/rst.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bitscan_encoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bitscan_encoder_if #(.N(8), .W(3)) bus_l ();
  bitscan_encoder_if #(.N(8), .W(3)) bus_m ();

  bitscan_encoder #(.N(8), .W(3), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  bitscan_encoder #(.N(8), .W(3), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid: got %0d expected 0", bus_l.o_valid); end
    total++;
    if (bus_l.o !== 3'd0) begin bad++; $display("FAIL reset_o: got %0d expected 0", bus_l.o); end
    total++;
    if (bus_l.o_last !== 1'b0) begin bad++; $display("FAIL reset_o_last: got %0d expected 0", bus_l.o_last); end
`ifdef ENC_ZERO_EVT_EN
    total++;
    if (bus_l.o_zero !== 1'b0) begin bad++; $display("FAIL reset_o_zero: got %0d expected 0", bus_l.o_zero); end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus_l.i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready: got %0d expected 1", bus_l.i_ready); end
    total++;
    if (bus_m.i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready_msb: got %0d expected 1", bus_m.i_ready); end
  endtask

  task automatic test_lsb_first();
    logic [2:0] exp_idx [3];
    exp_idx = '{3'd2, 3'd5, 3'd7};
    bus_l.o_ready = 1'b1;
    total++;
    if (bus_l.i_ready !== 1'b1) begin bad++; $display("FAIL lsb_i_ready: got %0d expected 1", bus_l.i_ready); end
    bus_l.i = 8'b1010_0100;
    bus_l.i_valid = 1'b1;
    @(negedge clk);
    bus_l.i_valid = 1'b0;
    bus_l.i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus_l.o_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid[%0d]: got %0d expected 1", k, bus_l.o_valid); end
      total++;
      if (bus_l.o !== exp_idx[k]) begin bad++; $display("FAIL lsb_o[%0d]: got %0d expected %0d", k, bus_l.o, exp_idx[k]); end
      total++;
      if (bus_l.o_last !== (k == 2)) begin bad++; $display("FAIL lsb_last[%0d]: got %0d expected %0d", k, bus_l.o_last, (k == 2)); end
      @(negedge clk);
    end
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL lsb_end_valid: got %0d expected 0", bus_l.o_valid); end
  endtask

  task automatic test_msb_first();
    logic [2:0] exp_idx [3];
    exp_idx = '{3'd7, 3'd5, 3'd2};
    bus_m.o_ready = 1'b1;
    bus_m.i = 8'b1010_0100;
    bus_m.i_valid = 1'b1;
    @(negedge clk);
    bus_m.i_valid = 1'b0;
    bus_m.i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus_m.o_valid !== 1'b1) begin bad++; $display("FAIL msb_valid[%0d]: got %0d expected 1", k, bus_m.o_valid); end
      total++;
      if (bus_m.o !== exp_idx[k]) begin bad++; $display("FAIL msb_o[%0d]: got %0d expected %0d", k, bus_m.o, exp_idx[k]); end
      total++;
      if (bus_m.o_last !== (k == 2)) begin bad++; $display("FAIL msb_last[%0d]: got %0d expected %0d", k, bus_m.o_last, (k == 2)); end
      @(negedge clk);
    end
    total++;
    if (bus_m.o_valid !== 1'b0) begin bad++; $display("FAIL msb_end_valid: got %0d expected 0", bus_m.o_valid); end
  endtask

  task automatic test_stall();
    bus_l.o_ready = 1'b0;
    bus_l.i = 8'b0001_1000;
    bus_l.i_valid = 1'b1;
    @(negedge clk);
    bus_l.i_valid = 1'b0;
    bus_l.i = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus_l.o !== 3'd3 || bus_l.o_valid !== 1'b1) begin
        bad++; $display("FAIL stall_o[%0d]: got o=%0d v=%0d expected o=3 v=1", k, bus_l.o, bus_l.o_valid);
      end
      total++;
      if (bus_l.o_last !== 1'b0) begin bad++; $display("FAIL stall_last[%0d]: got %0d expected 0", k, bus_l.o_last); end
      total++;
      if (bus_l.i_ready !== 1'b0) begin bad++; $display("FAIL stall_i_ready[%0d]: got %0d expected 0", k, bus_l.i_ready); end
      if (k == 2) bus_l.o_ready = 1'b1;
      @(negedge clk);
    end
    total++;
    if (bus_l.o !== 3'd4 || bus_l.o_last !== 1'b1 || bus_l.o_valid !== 1'b1) begin
      bad++; $display("FAIL stall_final: got o=%0d last=%0d v=%0d expected o=4 last=1 v=1", bus_l.o, bus_l.o_last, bus_l.o_valid);
    end
    @(negedge clk);
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL stall_end_valid: got %0d expected 0", bus_l.o_valid); end
    bus_l.i = 8'h00;
  endtask

  task automatic test_back_to_back();
    bus_l.o_ready = 1'b1;
    bus_l.i = 8'b1000_0000;
    bus_l.i_valid = 1'b1;
    @(negedge clk);
    bus_l.i = 8'b0000_0001;
    total++;
    if (bus_l.o !== 3'd7 || bus_l.o_last !== 1'b1 || bus_l.o_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got o=%0d last=%0d v=%0d expected o=7 last=1 v=1", bus_l.o, bus_l.o_last, bus_l.o_valid);
    end
    total++;
    if (bus_l.i_ready !== 1'b1) begin bad++; $display("FAIL b2b_i_ready: got %0d expected 1", bus_l.i_ready); end
    @(negedge clk);
    bus_l.i_valid = 1'b0;
    bus_l.i = 8'h00;
    total++;
    if (bus_l.o !== 3'd0 || bus_l.o_last !== 1'b1 || bus_l.o_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got o=%0d last=%0d v=%0d expected o=0 last=1 v=1", bus_l.o, bus_l.o_last, bus_l.o_valid);
    end
    @(negedge clk);
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %0d expected 0", bus_l.o_valid); end
  endtask

  task automatic test_zero_vector();
    bus_l.o_ready = 1'b1;
    bus_l.i = 8'h00;
    bus_l.i_valid = 1'b1;
    @(negedge clk);
    bus_l.i_valid = 1'b0;
`ifdef ENC_ZERO_EVT_EN
    total++;
    if (bus_l.o_valid !== 1'b1 || bus_l.o !== 3'd0 || bus_l.o_zero !== 1'b1 || bus_l.o_last !== 1'b1) begin
      bad++; $display("FAIL zero_beat: got v=%0d o=%0d z=%0d last=%0d expected v=1 o=0 z=1 last=1",
                      bus_l.o_valid, bus_l.o, bus_l.o_zero, bus_l.o_last);
    end
    @(negedge clk);
    total++;
    if (bus_l.o_valid !== 1'b0 || bus_l.o_zero !== 1'b0) begin
      bad++; $display("FAIL zero_end: got v=%0d z=%0d expected v=0 z=0", bus_l.o_valid, bus_l.o_zero);
    end
`else
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL zero_dropped: got o_valid=%0d expected 0", bus_l.o_valid); end
    total++;
    if (bus_l.i_ready !== 1'b1) begin bad++; $display("FAIL zero_i_ready: got %0d expected 1", bus_l.i_ready); end
    @(negedge clk);
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL zero_still_idle: got o_valid=%0d expected 0", bus_l.o_valid); end
`endif
  endtask

  task automatic test_reset_mid_scan();
    bus_l.o_ready = 1'b1;
    bus_l.i = 8'hFF;
    bus_l.i_valid = 1'b1;
    @(negedge clk);
    bus_l.i_valid = 1'b0;
    bus_l.i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus_l.o !== k[2:0] || bus_l.o_valid !== 1'b1) begin
        bad++; $display("FAIL ff_beat[%0d]: got o=%0d v=%0d expected o=%0d v=1", k, bus_l.o, bus_l.o_valid, k);
      end
      if (k < 2) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %0d expected 0", bus_l.o_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus_l.i_ready !== 1'b1) begin bad++; $display("FAIL rst_release_i_ready: got %0d expected 1", bus_l.i_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (bus_l.o_valid !== 1'b0) begin bad++; $display("FAIL rst_no_beats[%0d]: got o_valid=%0d o=%0d expected 0", k, bus_l.o_valid, bus_l.o); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus_l.i = 8'h00;
    bus_l.i_valid = 1'b0;
    bus_l.o_ready = 1'b1;
    bus_m.i = 8'h00;
    bus_m.i_valid = 1'b0;
    bus_m.o_ready = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_zero_vector();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
